// File: rtl/vedic_mult_pipe_if.sv
// vedic_mult_pipe_if: operand/result handshake bundle for vedic_mult_pipe (sgn exists only with VEDIC_SIGNED_EN)
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
`ifdef VEDIC_SIGNED_EN
    logic               sgn;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic [CNT_W-1:0]   prod_count;
`ifdef VEDIC_SIGNED_EN
    modport master(output in_valid, a, b, sgn, out_ready, input in_ready, out_valid, result, prod_count);
    modport slave(input in_valid, a, b, sgn, out_ready, output in_ready, out_valid, result, prod_count);
`else
    modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, result, prod_count);
    modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, result, prod_count);
`endif
endinterface

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined Urdhva-Tiryagbhyam multiplier with valid/ready; VEDIC_SIGNED_EN adds signed mode
module vedic_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    vedic_mult_pipe_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
    end
    logic             v0, v1, v2;
    logic             en0, en1, en2;
    logic             neg_in, neg0, neg1;
    logic [WIDTH-1:0] am, bm, a0, b0;
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [WIDTH-1:0] ll, lh, hl, hh;
    logic [PW-1:0]    mag, sum, res;
    logic [CNT_W-1:0] cnt;
`ifdef VEDIC_SIGNED_EN
    always_comb begin
        am     = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        bm     = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        neg_in = bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end
`else
    always_comb begin
        am     = bus.a;
        bm     = bus.b;
        neg_in = 1'b0;
    end
`endif
    assign en2 = !v2 || bus.out_ready;
    assign en1 = !v1 || en2;
    assign en0 = !v0 || en1;
    assign bus.in_ready   = en0;
    assign bus.out_valid  = v2;
    assign bus.result     = res;
    assign bus.prod_count = cnt;
    vedic_mul #(.W(H)) u_ll (.a(a0[H-1:0]),     .b(b0[H-1:0]),     .p(pp_ll));
    vedic_mul #(.W(H)) u_lh (.a(a0[H-1:0]),     .b(b0[WIDTH-1:H]), .p(pp_lh));
    vedic_mul #(.W(H)) u_hl (.a(a0[WIDTH-1:H]), .b(b0[H-1:0]),     .p(pp_hl));
    vedic_mul #(.W(H)) u_hh (.a(a0[WIDTH-1:H]), .b(b0[WIDTH-1:H]), .p(pp_hh));
    assign mag = PW'(ll) + ((PW'(lh) + PW'(hl)) << H) + (PW'(hh) << WIDTH);
    assign sum = neg1 ? -mag : mag;
    always_ff @(posedge clk) begin
        if (rst) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            res <= '0;
            cnt <= '0;
        end else begin
            if (en0) v0 <= bus.in_valid;
            if (en1) v1 <= v0;
            if (en2) v2 <= v1;
            if (en2 && v1) res <= sum;
            if (v2 && bus.out_ready) cnt <= cnt + 1'b1;
        end
    end
    // Operand/partial-product registers only load alongside a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (en0 && bus.in_valid) begin
            a0   <= am;
            b0   <= bm;
            neg0 <= neg_in;
        end
        if (en1 && v0) begin
            ll   <= pp_ll;
            lh   <= pp_lh;
            hl   <= pp_hl;
            hh   <= pp_hh;
            neg1 <= neg0;
        end
    end
endmodule

module vedic_mul #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    if (W == 2) begin : g_base
        logic c;
        assign c    = a[1] & b[0] & a[0] & b[1];
        assign p[0] = a[0] & b[0];
        assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        assign p[2] = (a[1] & b[1]) ^ c;
        assign p[3] = a[1] & b[1] & c;
    end else begin : g_rec
        localparam int H  = W / 2;
        localparam int PW = 2 * W;
        logic [W-1:0] ll, lh, hl, hh;
        vedic_mul #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_mul #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
        vedic_mul #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_mul #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
        assign p = PW'(ll) + ((PW'(lh) + PW'(hl)) << H) + (PW'(hh) << W);
    end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed table plus handshake sequences for WIDTH=16, randomized-handshake exhaustive run for WIDTH=4
module tb_vedic_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vedic_mult_pipe_if #(.WIDTH(16), .CNT_W(16)) b16 ();
    vedic_mult_pipe_if #(.WIDTH(4),  .CNT_W(8))  b4 ();
    vedic_mult_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    vedic_mult_pipe #(.WIDTH(4),  .CNT_W(8))  dut4  (.clk(clk), .rst(rst), .bus(b4));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec_t;
    vec_t vecs[$];

    int passed = 0;
    int total  = 0;

    logic [15:0] sa[3] = '{16'd11, 16'd8, 16'd7};
    logic [15:0] sb[3] = '{16'd11, 16'd9, 16'd7};
    logic [31:0] sp[3] = '{32'd121, 32'd72, 32'd49};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
        b16.in_valid = v;
        b16.a = a;
        b16.b = b;
`ifdef VEDIC_SIGNED_EN
        b16.sgn = s;
`else
        if (s) $display("note: signed vector skipped in unsigned build");
`endif
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] r;
        logic [3:0] x, y;
        logic       s;
        int n, n4, sent, rcvd, cyc, ix, iy, cnt16;

        vecs.push_back('{16'hFFFF, 16'h00FF, 1'b0, 32'h00FEFF01});
        vecs.push_back('{16'h000B, 16'h000B, 1'b0, 32'd121});
        vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 32'h0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 32'h40000000});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 32'h00008000});
        vecs.push_back('{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00});
        vecs.push_back('{16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01});
`ifdef VEDIC_SIGNED_EN
        vecs.push_back('{16'hFFFF, 16'h0007, 1'b1, 32'hFFFFFFF9});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
        vecs.push_back('{16'h0007, 16'hFFF9, 1'b1, 32'hFFFFFFCF});
        vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000});
        b4.sgn = 1'b0;
`endif
        rst = 1'b1;
        drive16(1'b0, 16'h0, 16'h0, 1'b0);
        b16.out_ready = 1'b0;
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b0;
        b4.a = 4'h0;
        b4.b = 4'h0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", b16.out_valid, 0);
        chk("rst_result", b16.result, 0);
        chk("rst_count", b16.prod_count, 0);
        chk("rst_in_ready", b16.in_ready, 1);

        n = vecs.size();
        b16.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive16(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
            step();
            drive16(1'b0, 16'h0, 16'h0, 1'b0);
            step();
            chk("tbl_latency_n1", b16.out_valid, 0);
            step();
            chk("tbl_out_valid", b16.out_valid, 1);
            chk("tbl_result", b16.result, vecs[i].p);
            chk("tbl_count", b16.prod_count, i);
        end
        step();
        chk("tbl_count_end", b16.prod_count, n);
        chk("tbl_drained", b16.out_valid, 0);
        cnt16 = n;

        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                drive16(1'b1, sa[k], sb[k], 1'b0);
                chk("b2b_in_ready", b16.in_ready, 1);
            end else drive16(1'b0, 16'h0, 16'h0, 1'b0);
            step();
            if (k >= 2) begin
                chk("b2b_out_valid", b16.out_valid, 1);
                chk("b2b_result", b16.result, sp[k-2]);
            end
        end
        step();
        chk("b2b_drained", b16.out_valid, 0);
        cnt16 += 3;

        b16.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive16(1'b1, sa[k], sb[k], 1'b0);
            chk("bp_in_ready_accept", b16.in_ready, 1);
            step();
        end
        drive16(1'b0, 16'h0, 16'h0, 1'b0);
        chk("bp_full_in_ready", b16.in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", b16.out_valid, 1);
            chk("bp_hold_result", b16.result, 32'd121);
            chk("bp_hold_in_ready", b16.in_ready, 0);
        end
        b16.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", b16.in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_drain_valid", b16.out_valid, 1);
            chk("bp_drain_result", b16.result, sp[k]);
            step();
        end
        chk("bp_drained", b16.out_valid, 0);
        cnt16 += 3;
        chk("bp_count", b16.prod_count, cnt16);

        b16.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive16(1'b1, sa[k], sb[k], 1'b0);
            step();
        end
        rst = 1'b1;
        drive16(1'b1, 16'h3, 16'h3, 1'b0);
        step();
        rst = 1'b0;
        drive16(1'b0, 16'h0, 16'h0, 1'b0);
        chk("mrst_out_valid", b16.out_valid, 0);
        chk("mrst_result", b16.result, 0);
        chk("mrst_count", b16.prod_count, 0);
        chk("mrst_in_ready", b16.in_ready, 1);
        b16.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mrst_no_stale", b16.out_valid, 0);
        end

`ifdef VEDIC_SIGNED_EN
        n4 = 512;
`else
        n4 = 256;
`endif
        sent = 0;
        rcvd = 0;
        cyc = 0;
        while (rcvd < n4 && cyc < 20000) begin
            x = sent[3:0];
            y = sent[7:4];
            s = sent[8];
            b4.out_ready = ($urandom_range(0, 3) != 0);
            b4.in_valid = (sent < n4) && ($urandom_range(0, 3) != 0);
            b4.a = x;
            b4.b = y;
`ifdef VEDIC_SIGNED_EN
            b4.sgn = s;
`endif
            #3;
            if (b4.out_valid && b4.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL w4_spurious: got result %0h with nothing outstanding", b4.result);
                end else chk("w4_product", b4.result, exp_q.pop_front());
                rcvd++;
            end
            if (b4.in_valid && b4.in_ready) begin
                ix = (s && x[3]) ? int'(x) - 16 : int'(x);
                iy = (s && y[3]) ? int'(y) - 16 : int'(y);
                r = 8'(ix * iy);
                exp_q.push_back(r);
                sent++;
            end
            step();
            cyc++;
        end
        b4.in_valid = 1'b0;
        if (cyc >= 20000) begin
            total++;
            $display("FAIL w4_timeout: received %0d of %0d results", rcvd, n4);
        end
        chk("w4_received", rcvd, n4);
        chk("w4_queue_empty", exp_q.size(), 0);
        chk("w4_count_wrap", b4.prod_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
